seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 157 +++++++++++++++
 tb/tb_seq_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider -- sequential unsigned restoring divider.
//
// Produces one quotient bit per clock, MSB first, over WIDTH cycles.
// Results are registered on completion and held until the next operation
// completes or reset is applied.
//
// Optional feature (macro DIV_ZERO_EARLY_EN):
//   defined   -> a B=0 request skips the iterations and completes one edge
//                after start, reporting div_zero=1.
//   undefined -> B=0 runs through all WIDTH iterations; div_zero is tied 0.
//   The quotient/remainder values for B=0 are identical in both builds
//   (all ones / A).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   request a division (accepted in IDLE or DONE)
//   A          in   WIDTH  unsigned dividend
//   B          in   WIDTH  unsigned divisor
//   busy       out  high while iterating (RUN)
//   done       out  one-cycle pulse, results valid
//   quotient   out  WIDTH  A / B
//   remainder  out  WIDTH  A mod B
//   div_zero   out  divisor of the completed operation was zero
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvs_w;
    logic [WIDTH:0]   step;
    logic             accept;
    logic             last_iter;

    // One restoring iteration. Returns {quotient_bit, new_partial_remainder}.
    // Because the partial remainder stays below the divisor (or, for B=0,
    // holds only already-consumed dividend bits), the shifted value never
    // exceeds WIDTH+1 bits and bit WIDTH of the trial is a reliable sign.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] rem,
        input logic             din,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {rem, din};
        trial   = shifted - {1'b0, dvs};
        if (trial[WIDTH])
            return {1'b0, shifted[WIDTH-1:0]};
        else
            return {1'b1, trial[WIDTH-1:0]};
    endfunction

    // quo_w doubles as the dividend shift register: its MSB is the next
    // dividend bit, and quotient bits enter at the LSB.
    always_comb begin
        step       = restore_step(rem_w, quo_w[WIDTH-1], dvs_w);
        accept     = start && (state == IDLE || state == DONE);
        last_iter  = (cnt == '0);
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    state_next = RUN;
`ifdef DIV_ZERO_EARLY_EN
                    if (B == '0)
                        state_next = DONE;
`endif
                end
            end
            RUN: begin
                if (last_iter)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Working registers need no reset: they are always loaded on accept
    // before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            quo_w <= A;
            rem_w <= '0;
            dvs_w <= B;
            cnt   <= CNT_W'(WIDTH - 1);
        end else if (state == RUN) begin
            quo_w <= {quo_w[WIDTH-2:0], step[WIDTH]};
            rem_w <= step[WIDTH-1:0];
            cnt   <= cnt - 1'b1;
        end
    end

`ifdef DIV_ZERO_EARLY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == RUN && last_iter) begin
            quotient  <= {quo_w[WIDTH-2:0], step[WIDTH]};
            remainder <= step[WIDTH-1:0];
            div_zero  <= 1'b0;
        end else if (accept && B == '0) begin
            quotient  <= '1;
            remainder <= A;
            div_zero  <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (state == RUN && last_iter) begin
            quotient  <= {quo_w[WIDTH-2:0], step[WIDTH]};
            remainder <= step[WIDTH-1:0];
        end
    end

    assign div_zero = 1'b0;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 4;
`ifdef DIV_ZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           nbusy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.q     = (b == 0) ? {W{1'b1}} : a / b;
        e.r     = (b == 0) ? a : a % b;
        e.dz    = EARLY && (b == 0);
        e.lat   = (EARLY && b == 0) ? 1 : W + 1;
        e.nbusy = (EARLY && b == 0) ? 0 : W;
        sb.push_back(e);
    endtask

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        push_exp(a, b);
    endtask

    // Waits for done; lat is the number of edges taken (-1 on timeout).
    task automatic wait_done(input int budget, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got %0d want 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r got %0d want 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cases();
        logic [W-1:0] ta [8] = '{4'd13, 4'd15, 4'd0, 4'd6, 4'd5, 4'd0, 4'd15, 4'd11};
        logic [W-1:0] tb [8] = '{4'd4,  4'd1,  4'd7, 4'd6, 4'd0, 4'd0, 4'd15, 4'd5};
        int lat, nb;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            go(ta[k], tb[k]);
            wait_done(20, lat, nb);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL case%0d_latency got %0d want %0d", k, lat, e.lat); end
            checks++; if (nb !== e.nbusy) begin errors++; $display("FAIL case%0d_busy_cycles got %0d want %0d", k, nb, e.nbusy); end
            checks++; if (quotient !== e.q) begin errors++; $display("FAIL case%0d_q got %0d want %0d", k, quotient, e.q); end
            checks++; if (remainder !== e.r) begin errors++; $display("FAIL case%0d_r got %0d want %0d", k, remainder, e.r); end
            checks++; if (div_zero !== e.dz) begin errors++; $display("FAIL case%0d_dz got %b want %b", k, div_zero, e.dz); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL case%0d_done_pulse got %b want 0", k, done); end
        end
    endtask

    task automatic test_hold();
        int lat, nb;
        exp_t e;
        go(4'd14, 4'd4);
        wait_done(20, lat, nb);
        e = sb.pop_front();
        A = 4'd1;
        B = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL hold_q got %0d want %0d", quotient, e.q); end
        checks++; if (remainder !== e.r) begin errors++; $display("FAIL hold_r got %0d want %0d", remainder, e.r); end
    endtask

    task automatic test_ignore_start();
        int lat, nb;
        exp_t e;
        go(4'd9, 4'd3);
        tick();
        start = 1'b0;
        tick();
        A     = 4'd1;
        B     = 4'd1;
        start = 1'b1;
        wait_done(20, lat, nb);
        e = sb.pop_front();
        checks++; if (lat !== 3) begin errors++; $display("FAIL ignore_latency got %0d want 3", lat); end
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL ignore_q got %0d want %0d", quotient, e.q); end
        checks++; if (remainder !== e.r) begin errors++; $display("FAIL ignore_r got %0d want %0d", remainder, e.r); end
        tick();
    endtask

    task automatic test_abort();
        int lat, nb;
        exp_t e;
        A     = 4'd14;
        B     = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        A     = 4'd1;
        B     = 4'd1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (quotient !== '0) begin errors++; $display("FAIL abort_q got %0d want 0", quotient); end
        checks++; if (remainder !== '0) begin errors++; $display("FAIL abort_r got %0d want 0", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL abort_dz got %b want 0", div_zero); end
        wait_done(12, lat, nb);
        checks++; if (lat !== -1) begin errors++; $display("FAIL abort_spurious_done got latency %0d want none", lat); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL abort_idle_busy got %0d want 0", nb); end
        go(4'd14, 4'd3);
        wait_done(20, lat, nb);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL after_abort_latency got %0d want %0d", lat, e.lat); end
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL after_abort_q got %0d want %0d", quotient, e.q); end
        checks++; if (remainder !== e.r) begin errors++; $display("FAIL after_abort_r got %0d want %0d", remainder, e.r); end
        tick();
    endtask

    task automatic test_back_to_back();
        int   prev = -1;
        int   n    = 0;
        exp_t e;
        A     = 4'd7;
        B     = 4'd2;
        start = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(4'd7, 4'd2);
        for (int i = 0; i < 40 && n < 3; i++) begin
            tick();
            if (done) begin
                e = sb.pop_front();
                checks++; if (quotient !== e.q) begin errors++; $display("FAIL b2b%0d_q got %0d want %0d", n, quotient, e.q); end
                checks++; if (remainder !== e.r) begin errors++; $display("FAIL b2b%0d_r got %0d want %0d", n, remainder, e.r); end
                if (prev >= 0) begin
                    checks++; if (i - prev !== W + 1) begin errors++; $display("FAIL b2b%0d_period got %0d want %0d", n, i - prev, W + 1); end
                end
                prev = i;
                n++;
                if (n == 1) begin
                    tick();
                    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap_busy got %b want 1", busy); end
                    prev = prev;
                    i++;
                end
            end
        end
        start = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_cases();
        test_hold();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
